// File: rtl/display_scan_ctrl.sv
// Scan controller for a 4-digit seven-segment display: one-hot digit select with dead time,
// leading-zero blanking and a shadow value that only changes at frame boundaries.
module display_scan_ctrl #(
    parameter int SCAN_DIV = 50000,
    parameter int DEAD_CYC = 4,
    parameter int CNT_W    = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] bcd_in,
    input  logic        blank_lz,
    output logic [3:0]  num,
    output logic [3:0]  digit_sel,
    output logic        frame_done,
    output logic        bcd_err
);

    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_END  = CNT_W'(DEAD_CYC);

    logic [CNT_W-1:0] div_cnt;
    logic [1:0]       idx;
    logic [15:0]      shadow;
    logic [15:0]      pending;
    logic             pend_flag;

    logic             slot_wrap;
    logic             frame_wrap;
    logic             transfer;
    logic             shadow_bad;
    logic [3:0][3:0]  nib;
    logic [3:0][3:0]  digit_code;
    logic [3:0]       lz_blank;

    assign nib        = shadow;
    assign slot_wrap  = (div_cnt == SLOT_LAST);
    assign frame_wrap = enable && slot_wrap && (idx == 2'd3);
    // While dark there is no frame to tear, so a pending value may land immediately.
    assign transfer   = pend_flag && (frame_wrap || !enable);

    // lz_blank[k] is set when digits k..3 are all zero; digit 0 is never blanked this way.
    always_comb begin
        shadow_bad  = 1'b0;
        lz_blank    = 4'b0000;
        digit_code  = '0;
        lz_blank[3] = blank_lz && (nib[3] == 4'd0);
        lz_blank[2] = lz_blank[3] && (nib[2] == 4'd0);
        lz_blank[1] = lz_blank[2] && (nib[1] == 4'd0);
        for (int k = 0; k < 4; k++) begin
            if (nib[k] > 4'd9) begin
                shadow_bad    = 1'b1;
                digit_code[k] = 4'hF;
            end else if (lz_blank[k]) begin
                digit_code[k] = 4'hF;
            end else begin
                digit_code[k] = nib[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (!enable) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (slot_wrap) begin
            div_cnt <= '0;
            idx     <= idx + 2'd1;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

    // load is a one-cycle strobe with no back-pressure; a load coinciding with a transfer
    // re-arms pend_flag so the new value waits for the following boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow    <= '0;
            pending   <= '0;
            pend_flag <= 1'b0;
        end else begin
            if (transfer) begin
                shadow <= pending;
            end
            if (load) begin
                pending   <= bcd_in;
                pend_flag <= 1'b1;
            end else if (transfer) begin
                pend_flag <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num        <= 4'hF;
            digit_sel  <= 4'b0000;
            frame_done <= 1'b0;
            bcd_err    <= 1'b0;
        end else begin
            frame_done <= frame_wrap;
            bcd_err    <= shadow_bad;
            if (!enable || (div_cnt < DEAD_END)) begin
                num       <= 4'hF;
                digit_sel <= 4'b0000;
            end else begin
                num       <= digit_code[idx];
                digit_sel <= 4'b0001 << idx;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: a position-based model feeds an expected queue checked every
// cycle, while directed scenarios pin hand-computed digit values at chosen slot positions.
module tb_display_scan_ctrl;

    localparam int SCAN_DIV = 8;
    localparam int DEAD_CYC = 2;
    localparam int FRAME    = 4 * SCAN_DIV;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        enable   = 1'b0;
    logic        load     = 1'b0;
    logic        blank_lz = 1'b0;
    logic [15:0] bcd_in   = 16'h0000;
    logic [3:0]  num;
    logic [3:0]  digit_sel;
    logic        frame_done;
    logic        bcd_err;

    int n_pass  = 0;
    int n_total = 0;

    logic [3:0] scan_num [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
    logic [3:0] sel_tab  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    display_scan_ctrl #(
        .SCAN_DIV(SCAN_DIV),
        .DEAD_CYC(DEAD_CYC),
        .CNT_W   (20)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .load      (load),
        .bcd_in    (bcd_in),
        .blank_lz  (blank_lz),
        .num       (num),
        .digit_sel (digit_sel),
        .frame_done(frame_done),
        .bcd_err   (bcd_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_out(input string name, input logic [3:0] e_num, input logic [3:0] e_sel);
        check({name, "_num"}, 16'(num), 16'(e_num));
        check({name, "_sel"}, 16'(digit_sel), 16'(e_sel));
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_num"}, 16'(num), 16'hF);
        check({name, "_sel"}, 16'(digit_sel), 16'h0);
        check({name, "_fd"}, 16'(frame_done), 16'h0);
        check({name, "_err"}, 16'(bcd_err), 16'h0);
    endtask

    task automatic check_word(input logic [9:0] w);
        check("model_num", 16'(num), 16'(w[9:6]));
        check("model_sel", 16'(digit_sel), 16'(w[5:2]));
        check("model_fd", 16'(frame_done), 16'(w[1]));
        check("model_err", 16'(bcd_err), 16'(w[0]));
    endtask

    // ---------------- behavioural model ----------------
    // m_pos counts enabled cycles since scanning (re)started; slot and digit follow by division.
    logic [15:0] m_shadow;
    logic [15:0] m_pending;
    logic        m_pflag;
    int          m_pos;
    logic [9:0]  exp_q [$];

    function automatic logic at_boundary(input int pos, input logic en);
        return en && ((pos % FRAME) == FRAME - 1);
    endfunction

    function automatic logic [3:0] shown(input logic [15:0] v, input int k, input logic blz);
        logic [3:0] d;
        d = v[4*k +: 4];
        if (d > 4'd9) return 4'hF;
        if (blz && (k > 0) && ((v >> (4*k)) == 16'd0)) return 4'hF;
        return d;
    endfunction

    function automatic logic [9:0] model_out(input int pos, input logic [15:0] sh,
                                             input logic en, input logic blz);
        int         slot;
        logic [3:0] e_num;
        logic [3:0] e_sel;
        logic       bad;
        slot = (pos / SCAN_DIV) % 4;
        bad  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (sh[4*k +: 4] > 4'd9) bad = 1'b1;
        end
        if (!en || ((pos % SCAN_DIV) < DEAD_CYC)) begin
            e_num = 4'hF;
            e_sel = 4'b0000;
        end else begin
            e_num = shown(sh, slot, blz);
            e_sel = sel_tab[slot];
        end
        return {e_num, e_sel, at_boundary(pos, en), bad};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_shadow  <= 16'h0000;
            m_pending <= 16'h0000;
            m_pflag   <= 1'b0;
            m_pos     <= 0;
            exp_q.delete();
        end else begin
            exp_q.push_back(model_out(m_pos, m_shadow, enable, blank_lz));
            if (m_pflag && (!enable || at_boundary(m_pos, enable))) m_shadow <= m_pending;
            if (load) begin
                m_pending <= bcd_in;
                m_pflag   <= 1'b1;
            end else if (m_pflag && (!enable || at_boundary(m_pos, enable))) begin
                m_pflag <= 1'b0;
            end
            m_pos <= enable ? m_pos + 1 : 0;
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            check_reset_values("in_reset");
        end else if (exp_q.size() > 0) begin
            check_word(exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v);
        load   = 1'b1;
        bcd_in = v;
        @(negedge clk);
        load   = 1'b0;
    endtask

    // Returns on the falling edge where frame_done is seen (slot position 0 of the new frame).
    task automatic wait_fd();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3 * FRAME && !seen; i++) begin
            @(negedge clk);
            seen = frame_done;
        end
        check("frame_done_seen", 16'(seen), 16'h1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        #1 rst_n = 1'b0;
        #1 check_reset_values("por");
        adv(2);
        #1 rst_n = 1'b1;

        // scan order of 1234
        @(negedge clk);
        enable = 1'b1;
        do_load(16'h1234);
        wait_fd();
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            if (((k - 1) % SCAN_DIV) < DEAD_CYC)
                expect_out("scan_dead", 4'hF, 4'b0000);
            else
                expect_out("scan_lit", scan_num[(k - 1) / SCAN_DIV], sel_tab[(k - 1) / SCAN_DIV]);
            check("scan_fd", 16'(frame_done), 16'(k == FRAME));
        end

        // tear-free update, then two loads in one frame
        adv(12);
        expect_out("tear_before", 4'h3, 4'b0010);
        do_load(16'h5678);
        adv(7);
        expect_out("tear_old_d2", 4'h2, 4'b0100);
        adv(8);
        expect_out("tear_old_d3", 4'h1, 4'b1000);
        wait_fd();
        adv(4);
        expect_out("tear_new_d0", 4'h8, 4'b0001);
        adv(8);
        expect_out("tear_new_d1", 4'h7, 4'b0010);
        adv(16);
        expect_out("tear_new_d3", 4'h5, 4'b1000);
        do_load(16'h1111);
        do_load(16'h2222);
        wait_fd();
        adv(4);
        expect_out("last_wins_d0", 4'h2, 4'b0001);
        adv(24);
        expect_out("last_wins_d3", 4'h2, 4'b1000);

        // leading-zero blanking
        blank_lz = 1'b1;
        do_load(16'h0070);
        wait_fd();
        adv(4);
        expect_out("lz_d0", 4'h0, 4'b0001);
        adv(8);
        expect_out("lz_d1", 4'h7, 4'b0010);
        adv(8);
        expect_out("lz_d2", 4'hF, 4'b0100);
        adv(8);
        expect_out("lz_d3", 4'hF, 4'b1000);
        blank_lz = 1'b0;
        wait_fd();
        adv(20);
        expect_out("nolz_d2", 4'h0, 4'b0100);
        adv(8);
        expect_out("nolz_d3", 4'h0, 4'b1000);
        blank_lz = 1'b1;
        do_load(16'h0000);
        wait_fd();
        adv(4);
        expect_out("zero_d0", 4'h0, 4'b0001);
        adv(8);
        expect_out("zero_d1", 4'hF, 4'b0010);
        adv(16);
        expect_out("zero_d3", 4'hF, 4'b1000);

        // invalid BCD
        blank_lz = 1'b0;
        do_load(16'h12A4);
        wait_fd();
        check("err_at_boundary", 16'(bcd_err), 16'h0);
        adv(1);
        check("err_set", 16'(bcd_err), 16'h1);
        adv(11);
        expect_out("bad_d1", 4'hF, 4'b0010);
        adv(8);
        expect_out("bad_d2", 4'h2, 4'b0100);
        do_load(16'h1204);
        wait_fd();
        check("err_hold", 16'(bcd_err), 16'h1);
        adv(1);
        check("err_clear", 16'(bcd_err), 16'h0);

        // enable drop mid-slot and restart
        adv(4);
        expect_out("en_before", 4'h4, 4'b0001);
        enable = 1'b0;
        do_load(16'h9876);
        expect_out("en_dark", 4'hF, 4'b0000);
        adv(3);
        enable = 1'b1;
        adv(1);
        expect_out("en_restart_dead", 4'hF, 4'b0000);
        adv(2);
        expect_out("en_restart_d0", 4'h6, 4'b0001);

        // asynchronous reset mid-slot drops the pending load
        adv(2);
        do_load(16'h4321);
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_rst");
        adv(2);
        #1 rst_n = 1'b1;
        wait_fd();
        adv(4);
        expect_out("post_rst_d0", 4'h0, 4'b0001);
        adv(8);
        expect_out("post_rst_d1", 4'h0, 4'b0010);

        adv(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Time-multiplexed scan controller for a 4-digit seven-segment display.
- Sits directly upstream of the seven-segment driver and feeds its num[3:0] and digit_sel[3:0] inputs.
- Holds a 4-digit BCD value in a shadow register and cycles a one-hot digit select at a programmable rate.
- Adds anti-ghosting dead time, leading-zero blanking and tear-free value updates at frame boundaries.

Parameters:
- SCAN_DIV, 50000, clock cycles per digit slot; legal range 2..2^20.
- DEAD_CYC, 4, cycles at the start of each slot with digit_sel forced to 0000; must be < SCAN_DIV.
- CNT_W, 20, width of the slot counter; must hold SCAN_DIV-1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  1 = scanning, 0 = display dark and counters held
- load  in  1  single-cycle strobe; captures bcd_in
- bcd_in  in  16  four BCD digits; [3:0] = digit 0 (rightmost), [15:12] = digit 3
- blank_lz  in  1  1 = blank leading zeros
- num  out  4  digit code to the driver; 4'hF = blank (decodes to all segments off)
- digit_sel  out  4  one-hot digit enable to the driver; 0001 = digit 0
- frame_done  out  1  one-cycle pulse at each 3->0 wrap
- bcd_err  out  1  high while the shadow value holds any nibble > 9

Behaviour:
- Reset (async assert, sync release): num=4'hF, digit_sel=0000, frame_done=0, bcd_err=0, shadow=0, pending=0, pend_flag=0, div_cnt=0, idx=0.
- Load: when load=1, bcd_in goes to the pending register and pend_flag is set. Several loads before a boundary: last value wins. Load in the same cycle as a transfer: the new value goes to pending and is shown in the next frame.
- Counters (enable=1): div_cnt counts 0..SCAN_DIV-1 and wraps. On wrap, idx increments mod 4.
- Frame boundary: the cycle where div_cnt wraps with idx=3.
  - frame_done pulses for 1 cycle.
  - If pend_flag=1: shadow <= pending, pend_flag cleared.
- enable=0:
  - div_cnt and idx are held at 0.
  - Outputs are num=F, digit_sel=0000.
  - A pending value transfers to shadow on the next clock.
  - Re-enable starts at digit 0, slot cycle 0.
- Output timing: num and digit_sel are registered and lag the counter state by exactly 1 clock.
  - Dead time: div_cnt < DEAD_CYC gives digit_sel=0000, num=F.
  - Otherwise digit_sel=onehot(idx) and num=digit(idx) after blanking rules.
- Blanking rules, in priority order:
  - A nibble > 9 outputs F.
  - If blank_lz=1, digit k (k=1..3) outputs F when digits k..3 are all zero.
  - Digit 0 is never leading-zero blanked.
- bcd_err: registered, updated the cycle after a shadow update. Set if any shadow nibble > 9, cleared otherwise.
- Frame period: exactly 4*SCAN_DIV cycles. Each digit is lit for SCAN_DIV-DEAD_CYC cycles per frame.
- Reset mid-frame: immediate return to reset values; the pending value is discarded.

Test Plan:
- Scan order (SCAN_DIV=8, DEAD_CYC=2): reset, enable=1, load 16'h1234 -> after the first frame_done, digit_sel repeats 0000 x2 then 0001 x6 with num=4, then 0010 with num=3, 0100 with num=2, 1000 with num=1. frame_done pulses every 32 cycles.
- Tear-free update: load 16'h5678 mid-frame while 1234 is shown -> remaining digits of the current frame still show 1234. The next frame shows 8,7,6,5. Two loads in one frame -> only the last value appears.
- Leading zeros: load 16'h0070, blank_lz=1 -> digit 0 = 0, digit 1 = 7, digits 2-3 = F. blank_lz=0 -> 0,7,0,0. Load 16'h0000, blank_lz=1 -> digit 0 = 0, digits 1-3 = F.
- Invalid BCD: load 16'h12A4 -> after transfer, bcd_err=1 and digit 1 num=F. Then load 16'h1204 -> bcd_err clears one cycle after the next frame boundary.
- Enable and reset: drop enable mid-slot -> next cycle digit_sel=0000, num=F. Re-enable -> sequence restarts at digit 0 dead time. Assert rst_n low mid-slot -> outputs reach reset values without a clock edge; the pending load is lost.
